// File: rtl/keccak_state_serializer.sv
// keccak_state_serializer
// Captures a full 5x5 Keccak lane array and streams the first OUT_LANES lanes
// back out in string order (k -> A[k/5][k%5]) over a valid/ready handshake.
module keccak_state_serializer #(
    parameter int OUT_LANES = 4,
    parameter int LANE_W    = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [4:0][4:0][LANE_W-1:0]   state_i,
    input  logic                          state_valid_i,
    output logic                          state_ready_o,
    output logic [LANE_W-1:0]             word_o,
    output logic                          word_valid_o,
    input  logic                          word_ready_i,
    output logic                          word_last_o,
    output logic [4:0]                    word_idx_o,
    output logic                          busy_o
);

    localparam int         NUM_LANES = 25;
    localparam logic [4:0] LAST_IDX  = 5'(OUT_LANES - 1);

    // Refuse to build with an unsupported lane count or lane width.
    if (OUT_LANES < 1 || OUT_LANES > NUM_LANES || LANE_W != 64) begin : g_param_check
        $error("keccak_state_serializer: OUT_LANES must be 1..25 and LANE_W must be 64");
    end

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } fsm_t;

    fsm_t              fsm_q;
    fsm_t              fsm_d;
    logic [LANE_W-1:0] lane_in [NUM_LANES];
    logic [LANE_W-1:0] lane_p0 [NUM_LANES];
    logic [4:0]        cnt_p0;
    logic              vld_p0;
    logic              last_p0;
    logic              accept;
    logic              fire;

    // String order: lane k is A[k/5][k%5], taken unmodified.
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_order
        assign lane_in[k] = state_i[k / 5][k % 5];
    end

    assign accept = state_ready_o && state_valid_i;
    assign fire   = vld_p0 && word_ready_i;

    // FSM state register; reset wins over any handshake on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        fsm_d         = fsm_q;
        state_ready_o = 1'b0;
        vld_p0        = 1'b0;
        busy_o        = 1'b0;
        last_p0       = 1'b0;
        case (fsm_q)
            IDLE: begin
                state_ready_o = 1'b1;
                if (state_valid_i) begin
                    fsm_d = STREAM;
                end
            end
            STREAM: begin
                vld_p0  = 1'b1;
                busy_o  = 1'b1;
                last_p0 = (cnt_p0 == LAST_IDX);
                if (word_ready_i && last_p0) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // Lane buffer: loaded only on the accept edge so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_p0 <= '{default: '0};
        end else if (accept) begin
            lane_p0 <= lane_in;
        end
    end

    // Lane counter: restarts at 0 per block and after the last lane, so it
    // never passes OUT_LANES-1 and reads 0 while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p0 <= '0;
        end else if (accept) begin
            cnt_p0 <= '0;
        end else if (fire) begin
            cnt_p0 <= last_p0 ? 5'd0 : cnt_p0 + 5'd1;
        end
    end

    // Outputs come straight from the held buffer and counter, so they stay
    // stable for as long as the downstream stalls.
    assign word_o       = lane_p0[cnt_p0];
    assign word_idx_o   = cnt_p0;
    assign word_valid_o = vld_p0;
    assign word_last_o  = last_p0;

endmodule

// File: tb/tb_keccak_state_serializer.sv
// Scoreboard bench for keccak_state_serializer with three instances
// (OUT_LANES = 4, 25, 1) sharing one clock, reset and state bus.
module tb_keccak_state_serializer;

    typedef struct packed {
        logic [63:0] w;
        logic [4:0]  idx;
        logic        last;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    logic done = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    logic [63:0]           A [5][5];
    logic [4:0][4:0][63:0] st;

    logic        sv [3];
    logic        wr [3];
    logic        sr [3];
    logic [63:0] wo [3];
    logic        wv [3];
    logic        wl [3];
    logic [4:0]  wi [3];
    logic        bz [3];

    always_comb begin
        st = '0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                st[i][j] = A[i][j];
    end

    task automatic chk(input int g, input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL inst%0d %s actual=%h required=%h at %0t", g, nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rand_state();
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                A[i][j] = {$urandom, $urandom};
    endtask

    task automatic pattern_state();
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                A[i][j] = 64'h0100_0000_0000_0000 | 64'(5 * i + j);
    endtask

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int NL = (g == 0) ? 4 : (g == 1) ? 25 : 1;
        ent_t        q[$];
        ent_t        e;
        logic        stall = 1'b0;
        logic [63:0] hw;
        logic [4:0]  hi;
        logic        hl;

        keccak_state_serializer #(.OUT_LANES(NL), .LANE_W(64)) dut (
            .clk          (clk),
            .rst          (rst),
            .state_i      (st),
            .state_valid_i(sv[g]),
            .state_ready_o(sr[g]),
            .word_o       (wo[g]),
            .word_valid_o (wv[g]),
            .word_ready_i (wr[g]),
            .word_last_o  (wl[g]),
            .word_idx_o   (wi[g]),
            .busy_o       (bz[g])
        );

        // Input-side scoreboard push and output-side monitor, sampled mid-cycle.
        always @(negedge clk) begin
            if (rst) begin
                q.delete();
                stall = 1'b0;
            end else begin
                chk(g, "busy_eq_valid", 64'(bz[g]), 64'(wv[g]));
                chk(g, "ready_eq_not_valid", 64'(sr[g]), 64'(!wv[g]));
                if (stall) begin
                    chk(g, "hold_valid", 64'(wv[g]), 64'd1);
                    chk(g, "hold_word", wo[g], hw);
                    chk(g, "hold_idx", 64'(wi[g]), 64'(hi));
                    chk(g, "hold_last", 64'(wl[g]), 64'(hl));
                end
                if (wv[g] && wr[g]) begin
                    if (q.size() == 0) begin
                        chk(g, "unexpected_word", 64'd1, 64'd0);
                    end else begin
                        e = q.pop_front();
                        chk(g, "word", wo[g], e.w);
                        chk(g, "idx", 64'(wi[g]), 64'(e.idx));
                        chk(g, "last", 64'(wl[g]), 64'(e.last));
                    end
                end
                stall = wv[g] && !wr[g];
                hw = wo[g];
                hi = wi[g];
                hl = wl[g];
                if (sv[g] && sr[g]) begin
                    for (int k = 0; k < NL; k++)
                        q.push_back(ent_t'{A[k / 5][k % 5], 5'(k), (k == NL - 1)});
                end
            end
        end

        always @(posedge done) chk(g, "queue_drained", 64'(q.size()), 64'd0);
    end

    initial begin
        int n;
        rst = 1'b1;
        for (int g = 0; g < 3; g++) begin
            sv[g] = 1'b0;
            wr[g] = 1'b0;
        end
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                A[i][j] = '0;
        cyc(2);
        for (int g = 0; g < 3; g++) begin
            chk(g, "rst_word", wo[g], 64'd0);
            chk(g, "rst_valid", 64'(wv[g]), 64'd0);
            chk(g, "rst_last", 64'(wl[g]), 64'd0);
            chk(g, "rst_idx", 64'(wi[g]), 64'd0);
            chk(g, "rst_busy", 64'(bz[g]), 64'd0);
            chk(g, "rst_ready", 64'(sr[g]), 64'd1);
        end
        rst = 1'b0;
        cyc(1);

        // Basic stream on the 4-lane instance.
        pattern_state();
        wr[0] = 1'b1;
        sv[0] = 1'b1;
        cyc(1);
        sv[0] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk(0, "basic_valid", 64'(wv[0]), 64'd1);
            chk(0, "basic_idx", 64'(wi[0]), 64'(c));
            chk(0, "basic_last", 64'(wl[0]), 64'(c == 3));
            chk(0, "basic_word", wo[0], 64'h0100_0000_0000_0000 | 64'(c));
            cyc(1);
        end
        chk(0, "basic_idle_valid", 64'(wv[0]), 64'd0);
        chk(0, "basic_idle_ready", 64'(sr[0]), 64'd1);

        // Backpressure on idx 1 for three cycles.
        sv[0] = 1'b1;
        cyc(1);
        sv[0] = 1'b0;
        cyc(1);
        wr[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk(0, "stall_valid", 64'(wv[0]), 64'd1);
            chk(0, "stall_idx", 64'(wi[0]), 64'd1);
            chk(0, "stall_word", wo[0], 64'h0100_0000_0000_0001);
            cyc(1);
        end
        wr[0] = 1'b1;
        chk(0, "stall_release_idx", 64'(wi[0]), 64'd1);
        cyc(3);
        chk(0, "stall_idle_ready", 64'(sr[0]), 64'd1);

        // Full 25-lane state.
        rand_state();
        A[0][0] = 64'h1;
        A[4][4] = 64'hDEAD_BEEF_CAFE_F00D;
        wr[1] = 1'b1;
        sv[1] = 1'b1;
        cyc(1);
        sv[1] = 1'b0;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (wv[1] && wr[1]) begin
                if (wi[1] == 5'd0) chk(1, "full_word0", wo[1], 64'h1);
                if (wi[1] == 5'd24) begin
                    chk(1, "full_word24", wo[1], 64'hDEAD_BEEF_CAFE_F00D);
                    chk(1, "full_last24", 64'(wl[1]), 64'd1);
                end
                n++;
            end
            cyc(1);
        end
        chk(1, "full_handshakes", 64'(n), 64'd25);

        // Input isolation: all-ones and valid held during the stream.
        pattern_state();
        sv[0] = 1'b1;
        cyc(1);
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                A[i][j] = '1;
        cyc(4);
        chk(0, "iso_idle_ready", 64'(sr[0]), 64'd1);
        chk(0, "iso_idle_valid", 64'(wv[0]), 64'd0);
        cyc(1);
        sv[0] = 1'b0;
        chk(0, "iso_second_valid", 64'(wv[0]), 64'd1);
        chk(0, "iso_second_idx", 64'(wi[0]), 64'd0);
        chk(0, "iso_second_word", wo[0], '1);
        cyc(4);

        // Reset in the middle of a stream.
        rand_state();
        sv[0] = 1'b1;
        cyc(1);
        sv[0] = 1'b0;
        cyc(3);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk(0, "abort_valid", 64'(wv[0]), 64'd0);
        chk(0, "abort_busy", 64'(bz[0]), 64'd0);
        chk(0, "abort_idx", 64'(wi[0]), 64'd0);
        chk(0, "abort_ready", 64'(sr[0]), 64'd1);
        chk(0, "abort_last", 64'(wl[0]), 64'd0);
        rand_state();
        sv[0] = 1'b1;
        cyc(1);
        sv[0] = 1'b0;
        chk(0, "restart_valid", 64'(wv[0]), 64'd1);
        chk(0, "restart_idx", 64'(wi[0]), 64'd0);
        cyc(4);

        // Single-lane instance.
        rand_state();
        wr[2] = 1'b1;
        sv[2] = 1'b1;
        cyc(1);
        sv[2] = 1'b0;
        chk(2, "one_valid", 64'(wv[2]), 64'd1);
        chk(2, "one_idx", 64'(wi[2]), 64'd0);
        chk(2, "one_last", 64'(wl[2]), 64'd1);
        chk(2, "one_word", wo[2], A[0][0]);
        cyc(1);
        chk(2, "one_idle_valid", 64'(wv[2]), 64'd0);
        chk(2, "one_idle_ready", 64'(sr[2]), 64'd1);

        // Randomized traffic on all instances.
        for (int c = 0; c < 400; c++) begin
            for (int g = 0; g < 3; g++) begin
                sv[g] = ($urandom_range(0, 2) == 0);
                wr[g] = ($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 3) == 0) rand_state();
            cyc(1);
        end
        for (int g = 0; g < 3; g++) begin
            sv[g] = 1'b0;
            wr[g] = 1'b1;
        end
        cyc(40);

        done = 1'b1;
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
